tlb_cp0_ctl: RTL
================

// Module: tlb_cp0_ctl
// PURPOSE
//  Upstream control stage for the TLB array. It holds the CP0 TLB registers:
//  Index, Random, EntryLo0, EntryLo1, PageMask, Wired and EntryHi.
//  It sequences the TLBP, TLBR, TLBWI and TLBWR instructions into the array's
//  index/re/we/entry ports and captures the array's outputs back into CP0.
//  It sits between the CP0 mtc0/mfc0 datapath and the TLB.
// PARAMETERS
//  ENTRY_ADDR_WIDTH  3  log2 of TLB entry count; MAX = 2**ENTRY_ADDR_WIDTH-1
// PORTS
//  clk              in   1   clock, rising edge
//  res              in   1   reset, asynchronous, active-high
//  cmd_valid        in   1   TLB instruction request; sampled only in IDLE
//  cmd_op           in   2   00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//  busy             out  1   high whenever state != IDLE
//  done             out  1   one-cycle pulse: instruction complete, regs updated
//  reg_we           in   1   mtc0 write strobe
//  reg_sel          in   3   0 Index, 1 Random, 2 Lo0, 3 Lo1, 4 PageMask,
//                            5 Wired, 6 EntryHi, 7 reserved
//  reg_wdata        in   32  mtc0 data
//  reg_rdata        out  32  mfc0 data, combinational on reg_sel; sel 7 reads 0
//  asid             out  8   EntryHi[7:0], continuous; used for TLB match
//  tlb_probe        out  1   high in PROBE; lookup vAddr mux selects tlb_probe_vaddr
//  tlb_probe_vaddr  out  32  EntryHi
//  tlb_index        out  W   array index for read/write
//  tlb_re, tlb_we   out  1   array read / write enables
//  tlb_hi_o, tlb_lo0_o, tlb_lo1_o, tlb_pm_o   out 32  write data = CP0 regs
//  tlb_hi_i, tlb_lo0_i, tlb_lo1_i, tlb_pm_i   in  32  array read data
//  tlb_found        in   1   lookup hit
//  tlb_matched_idx  in   W   lookup hit index
// BEHAVIOUR
//  Reset values:
//  - state IDLE; all regs 0 except Random = MAX.
//  - busy, done, tlb_re, tlb_we and tlb_probe are 0.
//  Register write masks (reg_we):
//  - Index: writes [W-1:0] only; P (bit31) is not software-writable.
//  - EntryHi: writes [31:13] and [7:0]; all other bits read 0.
//  - PageMask: writes [28:13]; all other bits read 0.
//  - Wired: writes [W-1:0].
//  - Lo0 and Lo1: all 32 bits writable.
//  - Random: read-only; writes are ignored.
//  Random:
//  - Decrements every cycle; when equal to Wired, next value is MAX.
//  - If Wired >= MAX, Random holds MAX.
//  - A Wired write forces Random = MAX on the next edge.
//  FSM: IDLE -> {PROBE | READ | WRITE} -> DONE -> IDLE.
//  - Entry into the op state happens on the edge where IDLE && cmd_valid.
//  - cmd_valid while busy is ignored; no queueing.
//  - PROBE: tlb_probe=1. At its end, Index is loaded:
//    - tlb_found=1: Index = {1'b0, 0, tlb_matched_idx}.
//    - else: Index[31] = 1, low bits unchanged.
//  - READ: tlb_re=1, tlb_index = Index[W-1:0].
//    - At its end, EntryHi, Lo0, Lo1 and PageMask load from the tlb_*_i ports.
//    - The same write masks as mtc0 apply.
//  - WRITE: tlb_we=1 for exactly one cycle; tlb_*_o = current regs.
//    - TLBWI: tlb_index = Index[W-1:0].
//    - TLBWR: tlb_index = Random value latched at accept.
//  - DONE: done=1 for one cycle, then IDLE.
//  - Latency: done is high 2 cycles after the accept edge; next accept is
//    possible on the cycle after done.
//  Simultaneous events:
//  - reg_we to a register captured in the same edge: the FSM capture wins.
//  - reg_we to other registers is always honoured, including while busy.
//  Reset mid-operation: return to IDLE at once; no tlb_we pulse and no done pulse.
// TESTING (W=3)
//  1. Random sequence:
//     - Wired=0: after reset Random reads 7,6,..,0,7.
//     - Write Wired=5: next Random is 7, then 7,6,5,7,6.
//  2. TLBWI:
//     - Setup: Index=3, EntryHi=0x0040_2005, Lo0=0x0000_1003, Lo1=0x0000_2003, PM=0.
//     - Required: one tlb_we cycle with tlb_index=3 and exactly those values;
//       done 2 cycles after accept.
//  3. TLBP:
//     - Hit (found=1, idx=6): Index=0x0000_0006.
//     - Then miss: Index=0x8000_0006.
//     - mtc0 Index=0xFFFF_FFFF reads back 0x0000_0007.
//  4. TLBR with Index=2, tlb_hi_i=0xFFFF_FFFF, tlb_pm_i=0xFFFF_FFFF:
//     - Required: EntryHi=0xFFFF_E0FF, PageMask=0x1FFF_E000.
//     - Required: Lo0 and Lo1 equal their inputs; tlb_re high one cycle.
//  5. TLBWR with Random=5 at accept: tlb_index=5.
//     - cmd_valid held through busy issues no second write until IDLE.
//  6. res pulse in the cycle after a TLBWI accept: no tlb_we, no done, regs = reset values.

Source files
------------

// File: rtl/tlb_cp0_ctl.sv
// CP0 TLB register file (Index, Random, EntryLo0/1, PageMask, Wired, EntryHi)
// and the sequencer that drives TLBP/TLBR/TLBWI/TLBWR into the TLB array.
module tlb_cp0_ctl #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        cmd_valid,
  input  logic [1:0]                  cmd_op,
  output logic                        busy,
  output logic                        done,
  input  logic                        reg_we,
  input  logic [2:0]                  reg_sel,
  input  logic [31:0]                 reg_wdata,
  output logic [31:0]                 reg_rdata,
  output logic [7:0]                  asid,
  output logic                        tlb_probe,
  output logic [31:0]                 tlb_probe_vaddr,
  output logic [ENTRY_ADDR_WIDTH-1:0] tlb_index,
  output logic                        tlb_re,
  output logic                        tlb_we,
  output logic [31:0]                 tlb_hi_o,
  output logic [31:0]                 tlb_lo0_o,
  output logic [31:0]                 tlb_lo1_o,
  output logic [31:0]                 tlb_pm_o,
  input  logic [31:0]                 tlb_hi_i,
  input  logic [31:0]                 tlb_lo0_i,
  input  logic [31:0]                 tlb_lo1_i,
  input  logic [31:0]                 tlb_pm_i,
  input  logic                        tlb_found,
  input  logic [ENTRY_ADDR_WIDTH-1:0] tlb_matched_idx
);

  localparam int W = ENTRY_ADDR_WIDTH;
  localparam logic [W-1:0] MAX     = {W{1'b1}};
  localparam logic [31:0]  HI_MASK = 32'hFFFF_E0FF;
  localparam logic [31:0]  PM_MASK = 32'h1FFF_E000;

  localparam logic [2:0] SEL_INDEX  = 3'd0;
  localparam logic [2:0] SEL_RANDOM = 3'd1;
  localparam logic [2:0] SEL_LO0    = 3'd2;
  localparam logic [2:0] SEL_LO1    = 3'd3;
  localparam logic [2:0] SEL_PM     = 3'd4;
  localparam logic [2:0] SEL_WIRED  = 3'd5;
  localparam logic [2:0] SEL_HI     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROBE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic         index_p;
  logic [W-1:0] index_lo;
  logic [W-1:0] random;
  logic [W-1:0] wired;
  logic [31:0]  entry_hi;
  logic [31:0]  entry_lo0;
  logic [31:0]  entry_lo1;
  logic [31:0]  page_mask;
  logic         wr_random;
  logic [W-1:0] rand_q;
  logic         accept;

  assign accept = (state == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00:   state_next = S_PROBE;
            2'b01:   state_next = S_READ;
            default: state_next = S_WRITE;
          endcase
        end
      end
      S_PROBE, S_READ, S_WRITE: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    tlb_probe = (state == S_PROBE);
    tlb_re    = (state == S_READ);
    tlb_we    = (state == S_WRITE);
    tlb_index = index_lo;
    if (state == S_WRITE && wr_random) tlb_index = rand_q;
  end

  // TLBWR must use the Random value seen at accept, not the one a cycle later.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_random <= 1'b0;
      rand_q    <= '0;
    end else if (accept) begin
      wr_random <= (cmd_op == 2'b11);
      rand_q    <= random;
    end
  end

  // A software write can set only the index bits; it always clears P.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      index_p  <= 1'b0;
      index_lo <= '0;
    end else if (state == S_PROBE) begin
      if (tlb_found) begin
        index_p  <= 1'b0;
        index_lo <= tlb_matched_idx;
      end else begin
        index_p  <= 1'b1;
      end
    end else if (reg_we && reg_sel == SEL_INDEX) begin
      index_p  <= 1'b0;
      index_lo <= reg_wdata[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wired  <= '0;
      random <= MAX;
    end else begin
      if (reg_we && reg_sel == SEL_WIRED) wired <= reg_wdata[W-1:0];
      if ((reg_we && reg_sel == SEL_WIRED) || wired == MAX || random == wired)
        random <= MAX;
      else
        random <= random - W'(1);
    end
  end

  // A TLBR capture takes priority over an mtc0 to the same register.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      entry_hi  <= '0;
      entry_lo0 <= '0;
      entry_lo1 <= '0;
      page_mask <= '0;
    end else if (state == S_READ) begin
      entry_hi  <= tlb_hi_i & HI_MASK;
      entry_lo0 <= tlb_lo0_i;
      entry_lo1 <= tlb_lo1_i;
      page_mask <= tlb_pm_i & PM_MASK;
    end else if (reg_we) begin
      case (reg_sel)
        SEL_HI:  entry_hi  <= reg_wdata & HI_MASK;
        SEL_LO0: entry_lo0 <= reg_wdata;
        SEL_LO1: entry_lo1 <= reg_wdata;
        SEL_PM:  page_mask <= reg_wdata & PM_MASK;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      SEL_INDEX:  reg_rdata = {index_p, {(31-W){1'b0}}, index_lo};
      SEL_RANDOM: reg_rdata = {{(32-W){1'b0}}, random};
      SEL_LO0:    reg_rdata = entry_lo0;
      SEL_LO1:    reg_rdata = entry_lo1;
      SEL_PM:     reg_rdata = page_mask;
      SEL_WIRED:  reg_rdata = {{(32-W){1'b0}}, wired};
      SEL_HI:     reg_rdata = entry_hi;
      default:    reg_rdata = '0;
    endcase
  end

  assign asid            = entry_hi[7:0];
  assign tlb_probe_vaddr = entry_hi;
  assign tlb_hi_o        = entry_hi;
  assign tlb_lo0_o       = entry_lo0;
  assign tlb_lo1_o       = entry_lo1;
  assign tlb_pm_o        = page_mask;

endmodule
